ccd_frame_streamer: RTL
=======================

CCD_FRAME_STREAMER -- requirements
Module: ccd_frame_streamer

Interface
REQ-001 Parameter ADC_W, default 12: ADC sample width; legal range 9..15.
REQ-002 Parameter FIFO_DEPTH, default 16: sample FIFO entries; power of two, minimum 4.
REQ-003 Parameter ADC_DLY, default 2: clk cycles from sp rising edge to adc_clk rise.
REQ-004 Parameter WR_HI, default 6: ft_wr high cycles per byte; minimum 1.
REQ-005 Parameter WR_LO, default 8: ft_wr low cycles after each byte; minimum 1.
REQ-006 Parameter SYNC_BYTE, default 8'hAA: trailer sync byte and reserved data value.
REQ-007 Parameter END_BYTE, default 8'hF5: first trailer byte.
REQ-008 clk  in  1  single clock for all logic (PLL main clock).
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 sp  in  1  pixel strobe from CCD timing generator; level, synchronous to clk.
REQ-011 frame_done  in  1  end-of-frame pulse, one or more cycles.
REQ-012 adc_d  in  ADC_W  ADC output data.
REQ-013 adc_of  in  1  ADC overrange.
REQ-014 ft_txe_n  in  1  USB FIFO transmit-empty, low = space available.
REQ-015 adc_clk  out  1  ADC conversion clock.
REQ-016 ft_d  out  8  USB FIFO write data.
REQ-017 ft_oe  out  1  ft_d drive enable for the top-level tristate.
REQ-018 ft_wr  out  1  USB FIFO write strobe; byte commits on high-to-low edge.
REQ-019 ovf  out  1  sticky: a sample or marker was dropped.
REQ-020 of_seen  out  1  sticky: adc_of sampled high during a capture.

Function
REQ-021 Capture: on sp 0->1, adc_clk SHALL rise ADC_DLY cycles later, stay high 2 cycles, and adc_d/adc_of SHALL be captured on the cycle adc_clk falls.
REQ-022 An sp rising edge during an active capture SHALL be ignored.
REQ-023 A captured sample SHALL be pushed as {tag=0, of, data} when FIFO occupancy < FIFO_DEPTH-1, else dropped with ovf set.
REQ-024 A frame_done rising edge SHALL set marker_pending; the marker {tag=1} SHALL be pushed on the first cycle with no sample push and occupancy < FIFO_DEPTH, else dropped with ovf set.
REQ-025 When a sample push and marker push coincide, the sample SHALL be pushed first and the marker on the next free cycle.
REQ-026 Writer FSM states: IDLE, POP, WAIT, STROBE, GAP; each entry emits 2 bytes.
REQ-027 IDLE->POP when FIFO non-empty; POP reads one entry and selects byte 0; POP->WAIT.
REQ-028 WAIT: hold while ft_txe_n=1; when 0, drive ft_d and ft_oe=1, ft_wr=1, go STROBE.
REQ-029 STROBE: hold ft_wr=1 for WR_HI cycles, then ft_wr=0, go GAP.
REQ-030 GAP: ft_wr=0 for WR_LO cycles; after byte 0 go WAIT with byte 1; after byte 1 go POP if FIFO non-empty, else IDLE.
REQ-031 Sample byte 0 = {bit7, zero-extension, data[ADC_W-1:8]}; byte 1 = data[7:0].
REQ-032 Any data byte equal to SYNC_BYTE SHALL be sent as SYNC_BYTE with bit 0 set.
REQ-033 Marker bytes SHALL be END_BYTE then SYNC_BYTE, never escaped.
REQ-034 ft_d SHALL stay stable from WAIT exit through GAP end; ft_oe=0 in IDLE.
REQ-035 FIFO SHALL be full-depth usable; read and write in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-036 While rst_n=0: adc_clk=0, ft_wr=0, ft_oe=0, ft_d=0, ovf=0, of_seen=0, FIFO empty, marker_pending=0, FSM=IDLE.
REQ-037 Reset mid-byte SHALL abort the byte immediately; no partial frame is resumed after release.
REQ-038 First sp edge SHALL be detected only after rst_n release, with the edge detector's previous-sp state cleared by reset.

Configuration
REQ-039 Macro CCD_OF_TAG_EN defined: byte 0 bit7 = sample's adc_of; undefined: bit7 = 0 and of_seen still operates.

Verification
REQ-040 ADC_W=12, adc_d=12'h5AA, txe low -> bytes 8'h05, 8'hAB; ft_wr high WR_HI cycles each.
REQ-041 frame_done after 3 samples -> 6 data bytes then 8'hF5, 8'hAA; no AA among data bytes.
REQ-042 ft_txe_n held high with 20 sp edges, FIFO_DEPTH=16 -> 15 samples kept, ovf=1, marker still accepted.
REQ-043 sp edge and frame_done coinciding with capture cycle -> sample bytes precede F5/AA.
REQ-044 CCD_OF_TAG_EN defined, adc_of=1, adc_d=12'h123 -> bytes 8'h81, 8'h23, of_seen=1.
REQ-045 rst_n low during STROBE -> ft_wr=0, ft_oe=0 same cycle; FIFO empty after release.

Source files
------------

// File: rtl/ccd_frame_streamer.sv
// ccd_frame_streamer: captures CCD ADC samples on pixel strobes and streams them as byte pairs to a USB FIFO
//   clk, rst_n      : single clock, asynchronous active-low reset
//   i_sp            : pixel strobe (level); a rising edge starts one ADC capture
//   i_frame_done    : end-of-frame; a rising edge queues a two-byte frame marker
//   i_adc_d/i_adc_of: ADC data and overrange, sampled as o_adc_clk falls
//   i_ft_txe_n      : USB FIFO has space when low
//   o_adc_clk       : ADC conversion clock
//   o_ft_d/o_ft_oe/o_ft_wr : USB FIFO byte, drive enable, write strobe (commits on fall)
//   o_ovf, o_of_seen: sticky drop flag, sticky ADC overrange flag
//   Macro CCD_OF_TAG_EN: when defined, byte 0 bit 7 carries the sample's overrange bit
module ccd_frame_streamer #(
  parameter int ADC_W = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int ADC_DLY = 2,
  parameter int WR_HI = 6,
  parameter int WR_LO = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter logic [7:0] END_BYTE = 8'hF5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sp,
  input  logic             i_frame_done,
  input  logic [ADC_W-1:0] i_adc_d,
  input  logic             i_adc_of,
  input  logic             i_ft_txe_n,
  output logic             o_adc_clk,
  output logic [7:0]       o_ft_d,
  output logic             o_ft_oe,
  output logic             o_ft_wr,
  output logic             o_ovf,
  output logic             o_of_seen
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ADC_W + 2;
  localparam int CW = $clog2(ADC_DLY + 3);
  localparam int TMAX = (WR_HI > WR_LO) ? WR_HI : WR_LO;
  localparam int TW = $clog2(TMAX) + 1;
  localparam logic [CW-1:0] C_HI0 = CW'(ADC_DLY);
  localparam logic [CW-1:0] C_HI1 = CW'(ADC_DLY + 1);
  localparam logic [CW-1:0] C_CAP = CW'(ADC_DLY + 2);
  localparam logic [AW:0] C_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] C_SFULL = (AW + 1)'(FIFO_DEPTH - 1);
  localparam logic [TW-1:0] C_HI_END = TW'(WR_HI - 1);
  localparam logic [TW-1:0] C_LO_END = TW'(WR_LO - 1);

  typedef enum logic [2:0] {IDLE, POP, WAIT, STROBE, GAP} state_t;

  logic             r_sp_prev, r_fd_prev, r_busy, r_mk_pend, r_adc_clk, r_ovf, r_of_seen;
  logic [CW-1:0]    r_cap_t;
  logic [AW:0]      r_wp, r_rp;
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  state_t           r_state;
  logic [EW-1:0]    r_ent;
  logic             r_sel;
  logic [TW-1:0]    r_tmr;
  logic [7:0]       r_ft_d;
  logic             r_ft_wr, r_ft_oe;

  logic             w_sp_rise, w_cap, w_mk, w_push_s, w_push_m, w_mk_drop, w_empty, w_of_tag;
  logic [CW-1:0]    w_t;
  logic [AW:0]      w_count;
  logic [EW-1:0]    w_wdata;
  logic [7:0]       w_raw, w_byte;

`ifdef CCD_OF_TAG_EN
  assign w_of_tag = i_adc_of;
`else
  assign w_of_tag = 1'b0;
`endif

  // Edges that arrive while a capture is in flight are ignored.
  assign w_sp_rise = i_sp & ~r_sp_prev & ~r_busy;
  assign w_t       = w_sp_rise ? '0 : r_cap_t;
  assign w_cap     = r_busy && (r_cap_t == C_CAP);
  assign w_count   = r_wp - r_rp;
  assign w_empty   = (r_wp == r_rp);
  // The last slot is reserved so a marker can still land behind a full run of samples.
  assign w_push_s  = w_cap && (w_count < C_SFULL);
  assign w_mk      = r_mk_pend | (i_frame_done & ~r_fd_prev);
  assign w_push_m  = w_mk && !w_push_s && (w_count < C_FULL);
  assign w_mk_drop = w_mk && !w_push_s && !(w_count < C_FULL);
  assign w_wdata   = w_push_s ? {1'b0, w_of_tag, i_adc_d} : {1'b1, {(EW - 1){1'b0}}};

  // Entry layout {tag, of, data}; tag=1 is a frame marker.
  assign w_raw  = r_sel ? r_ent[7:0] : {r_ent[ADC_W], 7'(r_ent[ADC_W-1:0] >> 8)};
  assign w_byte = r_ent[EW-1] ? (r_sel ? SYNC_BYTE : END_BYTE)
                              : ((w_raw == SYNC_BYTE) ? (w_raw | 8'h01) : w_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp_prev <= 1'b0;
      r_fd_prev <= 1'b0;
      r_busy    <= 1'b0;
      r_cap_t   <= '0;
      r_adc_clk <= 1'b0;
      r_mk_pend <= 1'b0;
      r_ovf     <= 1'b0;
      r_of_seen <= 1'b0;
      r_wp      <= '0;
    end else begin
      r_sp_prev <= i_sp;
      r_fd_prev <= i_frame_done;
      if (w_sp_rise || r_busy) begin
        r_adc_clk <= (w_t == C_HI0) || (w_t == C_HI1);
        r_busy    <= ~w_cap;
        r_cap_t   <= w_t + 1'b1;
      end
      if (w_cap && i_adc_of) r_of_seen <= 1'b1;
      if ((w_cap && !w_push_s) || w_mk_drop) r_ovf <= 1'b1;
      // A marker waits only when a sample takes this cycle's push slot.
      r_mk_pend <= w_mk && w_push_s;
      if (w_push_s || w_push_m) r_wp <= r_wp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_s || w_push_m) r_mem[r_wp[AW-1:0]] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rp    <= '0;
      r_ent   <= '0;
      r_sel   <= 1'b0;
      r_tmr   <= '0;
      r_ft_d  <= '0;
      r_ft_wr <= 1'b0;
      r_ft_oe <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ft_oe <= 1'b0;
          if (!w_empty) r_state <= POP;
        end
        POP: begin
          r_ent   <= r_mem[r_rp[AW-1:0]];
          r_rp    <= r_rp + 1'b1;
          r_sel   <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: if (!i_ft_txe_n) begin
          r_ft_d  <= w_byte;
          r_ft_oe <= 1'b1;
          r_ft_wr <= 1'b1;
          r_tmr   <= '0;
          r_state <= STROBE;
        end
        STROBE: begin
          r_tmr <= (r_tmr == C_HI_END) ? '0 : r_tmr + 1'b1;
          if (r_tmr == C_HI_END) begin
            r_ft_wr <= 1'b0;
            r_state <= GAP;
          end
        end
        GAP: begin
          r_tmr <= (r_tmr == C_LO_END) ? '0 : r_tmr + 1'b1;
          if (r_tmr == C_LO_END) begin
            r_sel   <= 1'b1;
            r_ft_oe <= !r_sel || !w_empty;
            r_state <= !r_sel ? WAIT : (w_empty ? IDLE : POP);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_adc_clk = r_adc_clk;
  assign o_ft_d    = r_ft_d;
  assign o_ft_oe   = r_ft_oe;
  assign o_ft_wr   = r_ft_wr;
  assign o_ovf     = r_ovf;
  assign o_of_seen = r_of_seen;
endmodule
